// File: rtl/clock_enable_ctrl.sv
// Multi-channel clock-enable generator with single-step trace mode and reset synchroniser.
// Define CLK_EN_CYCLE_CNT_EN to add the cycle_count output (count of clk_en[0] pulses).
module clock_enable_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int PS_WIDTH    = 5,
    parameter int CNT_WIDTH   = 31,
    parameter int SYNC_STAGES = 2
`ifdef CLK_EN_CYCLE_CNT_EN
    ,
    parameter int CYC_WIDTH   = 32
`endif
) (
    input  logic                         osc_clk,
    input  logic                         corrected_reset,
    input  logic                         trace_clk,
    input  logic                         trace_mode,
    input  logic [NUM_CH*PS_WIDTH-1:0]   ps_val,
    input  logic [NUM_CH-1:0]            ps_load,
    output logic [NUM_CH-1:0]            ps_ack,
    output logic [NUM_CH-1:0]            clk_en,
    output logic                         rst_sync,
    output logic                         trace_active
`ifdef CLK_EN_CYCLE_CNT_EN
    ,
    output logic [CYC_WIDTH-1:0]         cycle_count
`endif
);

    logic [SYNC_STAGES-1:0] rst_pipe;
    logic [SYNC_STAGES-1:0] mode_pipe;
    logic [SYNC_STAGES-1:0] tclk_pipe;
    logic                   tclk_prev;
    logic                   step;
    logic                   mode_next;

    function automatic logic [CNT_WIDTH-1:0] term_of(input logic [PS_WIDTH-1:0] ps);
        term_of = '0;
        for (int i = 0; i < CNT_WIDTH; i++) begin
            term_of[i] = (i < int'(ps));
        end
    endfunction

    function automatic logic [PS_WIDTH-1:0] clamp_ps(input logic [PS_WIDTH-1:0] ps);
        if (int'(ps) > CNT_WIDTH) begin
            clamp_ps = PS_WIDTH'(CNT_WIDTH);
        end else begin
            clamp_ps = ps;
        end
    endfunction

    always_ff @(posedge osc_clk or posedge corrected_reset) begin
        if (corrected_reset) begin
            rst_pipe  <= '1;
            mode_pipe <= '0;
            tclk_pipe <= '0;
            tclk_prev <= 1'b0;
        end else begin
            rst_pipe  <= {rst_pipe[SYNC_STAGES-2:0], 1'b0};
            mode_pipe <= {mode_pipe[SYNC_STAGES-2:0], trace_mode};
            tclk_pipe <= {tclk_pipe[SYNC_STAGES-2:0], trace_clk};
            tclk_prev <= tclk_pipe[SYNC_STAGES-1];
        end
    end

    assign rst_sync     = rst_pipe[SYNC_STAGES-1];
    assign trace_active = mode_pipe[SYNC_STAGES-1];
    assign step         = tclk_pipe[SYNC_STAGES-1] & ~tclk_prev;
    // Value trace_active takes on this edge; gating with it drops a step that lands on trace exit.
    assign mode_next    = mode_pipe[SYNC_STAGES-2];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt;
        logic [PS_WIDTH-1:0]  ps_act;
        logic [PS_WIDTH-1:0]  pend;
        logic                 pending;
        logic                 en_r;
        logic                 ack_r;
        logic                 at_term;
        logic                 apply;
        logic [PS_WIDTH-1:0]  load_val;
        logic [PS_WIDTH-1:0]  new_ps;

        always_comb begin
            load_val = clamp_ps(ps_val[c*PS_WIDTH +: PS_WIDTH]);
            at_term  = (cnt == term_of(ps_act));
            new_ps   = ps_load[c] ? load_val : pend;
            if (trace_active) begin
                apply = pending;
            end else begin
                apply = at_term & (pending | ps_load[c]);
            end
        end

        always_ff @(posedge osc_clk or posedge corrected_reset) begin
            if (corrected_reset) begin
                cnt     <= '0;
                ps_act  <= '0;
                pend    <= '0;
                pending <= 1'b0;
                en_r    <= 1'b0;
                ack_r   <= 1'b0;
            end else begin
                ack_r <= apply;
                if (apply) begin
                    ps_act  <= new_ps;
                    pending <= 1'b0;
                end else if (ps_load[c]) begin
                    pend    <= load_val;
                    pending <= 1'b1;
                end
                if (trace_active) begin
                    cnt  <= '0;
                    en_r <= step & mode_next;
                end else begin
                    cnt  <= at_term ? '0 : cnt + CNT_WIDTH'(1);
                    en_r <= at_term;
                end
            end
        end

        assign clk_en[c] = en_r;
        assign ps_ack[c] = ack_r;
    end

`ifdef CLK_EN_CYCLE_CNT_EN
    always_ff @(posedge osc_clk or posedge corrected_reset) begin
        if (corrected_reset) begin
            cycle_count <= '0;
        end else if (clk_en[0]) begin
            cycle_count <= cycle_count + CYC_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Bench for clock_enable_ctrl: per-cycle reference model plus directed scenarios.
// Building with CLK_EN_CYCLE_CNT_EN also checks cycle_count (4-bit counter so wrap is reachable).
module tb_clock_enable_ctrl;
    localparam int NUM_CH    = 2;
    localparam int PS_WIDTH  = 5;
    localparam int CNT_WIDTH = 31;
    localparam int SYNC      = 2;
    localparam int CYC_W     = 4;

    logic                       osc_clk;
    logic                       corrected_reset;
    logic                       trace_clk;
    logic                       trace_mode;
    logic [NUM_CH*PS_WIDTH-1:0] ps_val;
    logic [NUM_CH-1:0]          ps_load;
    logic [NUM_CH-1:0]          ps_ack;
    logic [NUM_CH-1:0]          clk_en;
    logic                       rst_sync;
    logic                       trace_active;
    logic [CYC_W-1:0]           cycle_count;

    clock_enable_ctrl #(
        .NUM_CH      (NUM_CH),
        .PS_WIDTH    (PS_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .SYNC_STAGES (SYNC)
`ifdef CLK_EN_CYCLE_CNT_EN
        ,
        .CYC_WIDTH   (CYC_W)
`endif
    ) dut (
        .osc_clk         (osc_clk),
        .corrected_reset (corrected_reset),
        .trace_clk       (trace_clk),
        .trace_mode      (trace_mode),
        .ps_val          (ps_val),
        .ps_load         (ps_load),
        .ps_ack          (ps_ack),
        .clk_en          (clk_en),
        .rst_sync        (rst_sync),
        .trace_active    (trace_active)
`ifdef CLK_EN_CYCLE_CNT_EN
        ,
        .cycle_count     (cycle_count)
`endif
    );

`ifndef CLK_EN_CYCLE_CNT_EN
    assign cycle_count = '0;
`endif

    initial begin
        osc_clk = 1'b0;
        forever #5 osc_clk = ~osc_clk;
    end

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: enables fall on edges that are whole multiples of 2^ps after the
    // channel's origin edge; synchronisers are pure sample delays of the async inputs.
    logic [NUM_CH-1:0] m_en;
    logic [NUM_CH-1:0] m_ack;
    logic              m_rst;
    logic              m_trace;
    logic [CYC_W-1:0]  m_cyc;
    longint            m_n;
    longint            m_org [NUM_CH];
    int                m_ps [NUM_CH];
    int                m_pend [NUM_CH];
    bit                m_pending [NUM_CH];
    bit                tm_h [SYNC+2];
    bit                tc_h [SYNC+2];

    always @(posedge osc_clk or posedge corrected_reset) begin
        if (corrected_reset) begin
            m_n = 0; m_en = '0; m_ack = '0; m_rst = 1'b1; m_trace = 1'b0; m_cyc = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_org[c] = 0; m_ps[c] = 0; m_pend[c] = 0; m_pending[c] = 1'b0;
            end
            for (int k = 0; k < SYNC+2; k++) begin
                tm_h[k] = 1'b0; tc_h[k] = 1'b0;
            end
        end else begin : model_edge
            bit pre, nxt, stp, ld, boundary, app;
            int v;
            logic [NUM_CH-1:0] en_n, ack_n;
            m_n++;
            if (m_en[0]) m_cyc++;
            for (int k = SYNC+1; k > 0; k--) begin
                tm_h[k] = tm_h[k-1]; tc_h[k] = tc_h[k-1];
            end
            tm_h[0] = trace_mode;
            tc_h[0] = trace_clk;
            pre = m_trace;
            nxt = tm_h[SYNC-1];
            stp = tc_h[SYNC] && !tc_h[SYNC+1];
            for (int c = 0; c < NUM_CH; c++) begin
                v = int'(ps_val[c*PS_WIDTH +: PS_WIDTH]);
                if (v > CNT_WIDTH) v = CNT_WIDTH;
                ld = ps_load[c];
                if (pre) begin
                    app = m_pending[c];
                    en_n[c] = stp && nxt;
                end else begin
                    boundary = ((m_n - m_org[c]) % (longint'(1) << m_ps[c])) == 0;
                    app = boundary && (m_pending[c] || ld);
                    en_n[c] = boundary;
                end
                ack_n[c] = app;
                if (app) begin
                    m_ps[c] = ld ? v : m_pend[c];
                    m_pending[c] = 1'b0;
                    m_org[c] = m_n;
                end else if (ld) begin
                    m_pend[c] = v;
                    m_pending[c] = 1'b1;
                end
                if (pre) m_org[c] = m_n;
            end
            m_en = en_n;
            m_ack = ack_n;
            m_trace = nxt;
            m_rst = (m_n < SYNC);
        end
    end

    initial begin
        forever begin
            @(posedge osc_clk);
            #1;
            if (chk_on) begin
                check("model clk_en", clk_en, m_en);
                check("model ps_ack", ps_ack, m_ack);
                check("model rst_sync", rst_sync, m_rst);
                check("model trace_active", trace_active, m_trace);
`ifdef CLK_EN_CYCLE_CNT_EN
                check("model cycle_count", cycle_count, m_cyc);
`endif
            end
        end
    end

    int pc0, pc1;

    task automatic run_count(input int n);
        repeat (n) begin
            @(negedge osc_clk);
            if (clk_en[0]) pc0++;
            if (clk_en[1]) pc1++;
        end
    endtask

    task automatic wait_en(input int ch, input int lim, output int w);
        w = 0;
        do begin
            @(negedge osc_clk);
            w++;
        end while (!clk_en[ch] && w < lim);
    endtask

    task automatic wait_trace(input logic val, input int lim);
        int n;
        n = 0;
        while (trace_active !== val && n < lim) begin
            @(negedge osc_clk);
            n++;
        end
        check("trace_active settle", trace_active, val);
    endtask

    initial begin
        int w, acks;
        corrected_reset = 1'b0;
        trace_clk = 1'b0;
        trace_mode = 1'b0;
        ps_val = '0;
        ps_load = '0;
        #1 corrected_reset = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(negedge osc_clk);

        // 1. reset state and release
        check("reset clk_en", clk_en, 2'b00);
        check("reset ps_ack", ps_ack, 2'b00);
        check("reset rst_sync", rst_sync, 1'b1);
        check("reset trace_active", trace_active, 1'b0);
        corrected_reset = 1'b0;
        @(negedge osc_clk);
        check("rst_sync after edge 1", rst_sync, 1'b1);
        check("clk_en after edge 1", clk_en, 2'b11);
        @(negedge osc_clk);
        check("rst_sync after edge 2", rst_sync, 1'b0);
        check("clk_en after edge 2", clk_en, 2'b11);

        // 2. ch1 exponent 3 applies immediately
        ps_val[PS_WIDTH +: PS_WIDTH] = 5'd3;
        ps_load = 2'b10;
        @(negedge osc_clk);
        ps_load = 2'b00;
        check("ch1 ack on load edge", ps_ack, 2'b10);
        pc0 = 0; pc1 = 0;
        run_count(32);
        check("ch1 pulses in 32 cycles", pc1, 4);

        // 3. ch0 exponent 2, then exponent 4 loaded at cnt==1
        ps_val[0 +: PS_WIDTH] = 5'd2;
        ps_load = 2'b01;
        @(negedge osc_clk);
        ps_load = 2'b00;
        check("ch0 ack exp 2", ps_ack[0], 1'b1);
        @(negedge osc_clk);
        check("ch0 idle at cnt 1", clk_en[0], 1'b0);
        ps_val[0 +: PS_WIDTH] = 5'd4;
        ps_load = 2'b01;
        @(negedge osc_clk);
        ps_load = 2'b00;
        check("ch0 no early ack", ps_ack[0], 1'b0);
        wait_en(0, 40, w);
        check("ch0 gap old period", w, 2);
        check("ch0 ack at old term", ps_ack[0], 1'b1);
        wait_en(0, 40, w);
        check("ch0 gap new period", w, 16);

        // 4. trace mode: three steps, then exit with ch1 at exponent 3
        trace_mode = 1'b1;
        wait_trace(1'b1, 10);
        @(negedge osc_clk);
        pc0 = 0; pc1 = 0;
        repeat (3) begin
            trace_clk = 1'b1;
            run_count(6);
            trace_clk = 1'b0;
            run_count(6);
        end
        check("trace pulses ch0", pc0, 3);
        check("trace pulses ch1", pc1, 3);
        trace_mode = 1'b0;
        wait_trace(1'b0, 10);
        wait_en(1, 20, w);
        check("ch1 first enable after exit", w, 8);

        // 5. reset in trace with a pending load
        trace_mode = 1'b1;
        wait_trace(1'b1, 10);
        ps_val[0 +: PS_WIDTH] = 5'd1;
        ps_load = 2'b01;
        @(negedge osc_clk);
        ps_load = 2'b00;
        trace_mode = 1'b0;
        corrected_reset = 1'b1;
        #1;
        check("mid reset clk_en", clk_en, 2'b00);
        check("mid reset ps_ack", ps_ack, 2'b00);
        check("mid reset rst_sync", rst_sync, 1'b1);
        check("mid reset trace_active", trace_active, 1'b0);
        repeat (3) @(negedge osc_clk);
        corrected_reset = 1'b0;
        acks = 0;
        repeat (20) begin
            @(negedge osc_clk);
            if (ps_ack != 2'b00) acks++;
        end
        check("no ack after reset", acks, 0);
        check("ps_act cleared by reset", clk_en, 2'b11);

`ifdef CLK_EN_CYCLE_CNT_EN
        // 6. cycle_count with ch0 at exponent 1
        corrected_reset = 1'b1;
        @(negedge osc_clk);
        corrected_reset = 1'b0;
        ps_val[0 +: PS_WIDTH] = 5'd1;
        ps_load = 2'b01;
        @(negedge osc_clk);
        ps_load = 2'b00;
        repeat (19) @(negedge osc_clk);
        check("cycle_count after 20", cycle_count, 10);
        repeat (10) @(negedge osc_clk);
        check("cycle_count at max", cycle_count, 15);
        repeat (2) @(negedge osc_clk);
        check("cycle_count wrap", cycle_count, 0);
`endif

        repeat (2) @(negedge osc_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1, "time limit");
    end

endmodule
